// File: rtl/flash_pkg.sv
// Shared opcodes, FSM state encoding and helpers for the SPI flash writer.
package flash_pkg;

  localparam logic [7:0] CMD_WREN  = 8'h06;
  localparam logic [7:0] CMD_PP    = 8'h02;
  localparam logic [7:0] CMD_SE    = 8'h20;
  localparam logic [7:0] CMD_RDSR1 = 8'h05;

  // Filler shifted out whenever no command is on the wire; keeps IO0 at 1.
  localparam logic [7:0] IDLE_BYTE  = 8'hFF;
  localparam logic [7:0] EXIT_BYTES = 8'd2;
  localparam logic [7:0] CMD_BYTES  = 8'd4;

  typedef enum logic [3:0] {
    IDLE,
    EXIT,
    GAP,
    WREN,
    CMD,
    DATA,
    POLL_CMD,
    POLL_RD,
    DONE
  } state_t;

  function automatic logic [7:0] addr_byte(input logic [23:0] addr,
                                           input logic [1:0]  idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = addr[23:16];
      2'd1:    b = addr[15:8];
      default: b = addr[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_shift8.sv
// 8-bit SPI shift register: parallel load, MSB-first shift-out with
// simultaneous shift-in, 3-bit bit counter and a byte-complete strobe.
module spi_shift8 (
  input  logic       clk,
  input  logic       resetn,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       advance,
  input  logic       sin,
  output logic       sout,
  output logic       byte_done
);

  logic [7:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;

  always_comb begin
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    if (load) begin
      sr_d      = load_data;
      bit_cnt_d = 3'd0;
    end else if (advance) begin
      sr_d      = {sr_q[6:0], sin};
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
  end

  // Reset to all ones so IO0 idles high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sr_q      <= 8'hFF;
      bit_cnt_q <= 3'd0;
    end else begin
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign sout      = sr_q[7];
  assign byte_done = advance && (bit_cnt_q == 3'd7);

endmodule

// File: rtl/flash_writer.sv
// SPI NOR flash sector-erase / page-program sequencer: exits continuous
// read mode, write-enables, issues the command, then polls WIP until done.
module flash_writer
  import flash_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 2,
  parameter logic [21:0] POLL_LIMIT = 22'h3FFFFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        op,
  input  logic [23:0] address,
  input  logic [7:0]  len_m1,
  input  logic [7:0]  din,
  output logic        din_next,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        mspi_cs,
  inout  wire         mspi_di,
  inout  wire         mspi_do,
  inout  wire         mspi_hold,
  inout  wire         mspi_wp
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  state_t        state_q, state_d;
  state_t        after_gap_q, after_gap_d;
  logic          cs_q, cs_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          timeout_q, timeout_d;
  logic          din_next_q, din_next_d;
  logic          op_q, op_d;
  logic [23:0]   addr_q, addr_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    byte_cnt_q, byte_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [21:0]   poll_cnt_q, poll_cnt_d;

  logic       sh_load;
  logic [7:0] sh_data;
  logic       sh_adv;
  logic       sh_out;
  logic       sh_done;

  spi_shift8 u_shift (
    .clk       (clk),
    .resetn    (resetn),
    .load      (sh_load),
    .load_data (sh_data),
    .advance   (sh_adv),
    .sin       (mspi_do),
    .sout      (sh_out),
    .byte_done (sh_done)
  );

  always_comb begin
    state_d     = state_q;
    after_gap_d = after_gap_q;
    cs_d        = cs_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
    timeout_d   = timeout_q;
    din_next_d  = 1'b0;
    op_d        = op_q;
    addr_d      = addr_q;
    len_d       = len_q;
    byte_cnt_d  = byte_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    poll_cnt_d  = poll_cnt_q;
    sh_load     = 1'b0;
    sh_data     = IDLE_BYTE;
    sh_adv      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d       = op;
          addr_d     = address;
          len_d      = len_m1;
          busy_d     = 1'b1;
          error_d    = 1'b0;
          timeout_d  = 1'b0;
          cs_d       = 1'b0;
          byte_cnt_d = 8'd0;
          sh_load    = 1'b1;
          state_d    = EXIT;
        end
      end

      EXIT: begin
        sh_adv = 1'b1;
        if (sh_done) begin
          sh_load = 1'b1;
          if (byte_cnt_q == EXIT_BYTES - 8'd1) begin
            state_d     = GAP;
            cs_d        = 1'b1;
            gap_cnt_d   = '0;
            after_gap_d = WREN;
          end else begin
            byte_cnt_d = byte_cnt_q + 8'd1;
          end
        end
      end

      // The first byte of the following command is loaded on the GAP exit
      // edge so its MSB is on IO0 in the very first cs-low cycle.
      GAP: begin
        gap_cnt_d = gap_cnt_q + GW'(1);
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d  = '0;
          state_d    = after_gap_q;
          cs_d       = 1'b0;
          byte_cnt_d = 8'd0;
          sh_load    = 1'b1;
          case (after_gap_q)
            WREN:    sh_data = CMD_WREN;
            CMD:     sh_data = op_q ? CMD_PP : CMD_SE;
            default: sh_data = CMD_RDSR1;
          endcase
        end
      end

      WREN: begin
        sh_adv = 1'b1;
        if (sh_done) begin
          sh_load     = 1'b1;
          state_d     = GAP;
          cs_d        = 1'b1;
          gap_cnt_d   = '0;
          after_gap_d = CMD;
        end
      end

      CMD: begin
        sh_adv = 1'b1;
        if (sh_done) begin
          sh_load = 1'b1;
          if (byte_cnt_q == CMD_BYTES - 8'd1) begin
            if (op_q) begin
              state_d    = DATA;
              sh_data    = din;
              din_next_d = 1'b1;
              byte_cnt_d = 8'd0;
            end else begin
              state_d     = GAP;
              cs_d        = 1'b1;
              gap_cnt_d   = '0;
              after_gap_d = POLL_CMD;
            end
          end else begin
            sh_data    = addr_byte(addr_q, byte_cnt_q[1:0]);
            byte_cnt_d = byte_cnt_q + 8'd1;
          end
        end
      end

      DATA: begin
        sh_adv = 1'b1;
        if (sh_done) begin
          sh_load = 1'b1;
          if (byte_cnt_q == len_q) begin
            state_d     = GAP;
            cs_d        = 1'b1;
            gap_cnt_d   = '0;
            after_gap_d = POLL_CMD;
          end else begin
            sh_data    = din;
            din_next_d = 1'b1;
            byte_cnt_d = byte_cnt_q + 8'd1;
          end
        end
      end

      POLL_CMD: begin
        sh_adv = 1'b1;
        if (sh_done) begin
          state_d    = POLL_RD;
          poll_cnt_d = 22'd0;
        end
      end

      // mspi_do on a byte-complete edge is bit 0 of that status byte (WIP).
      POLL_RD: begin
        sh_adv = 1'b1;
        if (sh_done) begin
          if (!mspi_do) begin
            state_d = DONE;
            cs_d    = 1'b1;
            sh_load = 1'b1;
          end else if (poll_cnt_q == POLL_LIMIT - 22'd1) begin
            state_d   = DONE;
            cs_d      = 1'b1;
            sh_load   = 1'b1;
            timeout_d = 1'b1;
          end else begin
            poll_cnt_d = poll_cnt_q + 22'd1;
          end
        end
      end

      DONE: begin
        done_d     = 1'b1;
        busy_d     = 1'b0;
        error_d    = timeout_q;
        poll_cnt_d = 22'd0;
        byte_cnt_d = 8'd0;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      after_gap_q <= IDLE;
      cs_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      timeout_q   <= 1'b0;
      din_next_q  <= 1'b0;
      op_q        <= 1'b0;
      addr_q      <= 24'd0;
      len_q       <= 8'd0;
      byte_cnt_q  <= 8'd0;
      gap_cnt_q   <= '0;
      poll_cnt_q  <= 22'd0;
    end else begin
      state_q     <= state_d;
      after_gap_q <= after_gap_d;
      cs_q        <= cs_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      timeout_q   <= timeout_d;
      din_next_q  <= din_next_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      byte_cnt_q  <= byte_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      poll_cnt_q  <= poll_cnt_d;
    end
  end

  assign mspi_cs   = cs_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign din_next  = din_next_q;
  assign mspi_di   = sh_out;
  assign mspi_hold = 1'b1;
  assign mspi_wp   = 1'b1;

endmodule

// File: tb/tb_flash_writer.sv
// Directed bench for flash_writer: a small flash model decodes IO0 bytes and
// answers status reads, while a vector table drives erase/program operations.
module tb_flash_writer;

  localparam int GAP = 2;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        op;
  logic [23:0] address;
  logic [7:0]  len_m1;
  logic [7:0]  din;
  logic        din_next;
  logic        busy;
  logic        done;
  logic        error;
  logic        mspi_cs;
  logic        flash_do;
  wire         mspi_di_w;
  wire         mspi_do_w;
  wire         mspi_hold_w;
  wire         mspi_wp_w;

  assign mspi_do_w = flash_do;

  flash_writer #(
    .GAP_CYCLES (GAP),
    .POLL_LIMIT (22'd4)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .op        (op),
    .address   (address),
    .len_m1    (len_m1),
    .din       (din),
    .din_next  (din_next),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .mspi_cs   (mspi_cs),
    .mspi_di   (mspi_di_w),
    .mspi_do   (mspi_do_w),
    .mspi_hold (mspi_hold_w),
    .mspi_wp   (mspi_wp_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [23:0] addr;
    logic [7:0]  len_m1;
    int          seed;
    int          wip_busy;
    bit          poke;
    logic [7:0]  exp_opcode;
    int          exp_status;
    logic        exp_error;
    int          exp_pulses;
  } vec_t;

  vec_t vecs[6];

  int checks;
  int failures;
  int cfg_seed;
  int cfg_wip;

  // Flash model state, written only by the model process.
  int         cyc;
  int         start_cyc;
  int         wren_cyc;
  int         seg;
  int         seg_bytes;
  int         nbits;
  int         status_cnt;
  int         pulses;
  int         last_pulse;
  int         bad_intervals;
  int         gap_runs;
  int         gap_bad;
  int         hi_run;
  int         data_idx;
  int         rd_bit;
  bit         rd_mode;
  bit         seen_low;
  logic [7:0] shreg;
  logic [7:0] status_val;
  logic [7:0] rx_q[$];

  function automatic logic [7:0] data_byte(input int seed, input int k);
    logic [7:0] b;
    if (seed == 0) begin
      case (k)
        0:       b = 8'hAA;
        1:       b = 8'h55;
        2:       b = 8'hC3;
        default: b = 8'h00;
      endcase
    end else begin
      b = 8'((k * 37 + seed * 11) & 255);
    end
    return b;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Flash model: samples IO0 mid-bit, answers RDSR with WIP=1 for cfg_wip
  // bytes, and presents the next program byte after each din_next pulse.
  initial begin
    flash_do = 1'b0;
    din      = 8'h00;
    cyc      = 0;
    shreg    = 8'h00;
    rd_mode  = 1'b0;
    rd_bit   = 7;
    hi_run   = 0;
    seen_low = 1'b0;
    seg      = 0;
    seg_bytes = 0;
    nbits    = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (start && !busy && resetn) begin
        rx_q.delete();
        seg           = 0;
        seg_bytes     = 0;
        nbits         = 0;
        status_cnt    = 0;
        pulses        = 0;
        last_pulse    = 0;
        bad_intervals = 0;
        gap_runs      = 0;
        gap_bad       = 0;
        hi_run        = 0;
        seen_low      = 1'b0;
        rd_mode       = 1'b0;
        data_idx      = 1;
        din           = data_byte(cfg_seed, 0);
        start_cyc     = cyc;
        wren_cyc      = 0;
      end
      if (mspi_cs) begin
        rd_mode = 1'b0;
        nbits   = 0;
        hi_run++;
      end else begin
        if (hi_run > 0) begin
          seg++;
          seg_bytes = 0;
          if (seen_low) begin
            gap_runs++;
            if (hi_run != GAP) gap_bad++;
          end
          if (seg == 2) wren_cyc = cyc;
        end
        hi_run   = 0;
        seen_low = 1'b1;
        if (rd_mode) begin
          status_val = (status_cnt < cfg_wip) ? 8'h03 : 8'h00;
          flash_do   = status_val[rd_bit];
          if (rd_bit == 0) begin
            rd_bit = 7;
            status_cnt++;
          end else begin
            rd_bit--;
          end
        end else begin
          shreg = {shreg[6:0], mspi_di_w};
          nbits++;
          if (nbits == 8) begin
            nbits = 0;
            rx_q.push_back(shreg);
            if (seg_bytes == 0 && shreg == 8'h05) begin
              rd_mode = 1'b1;
              rd_bit  = 7;
            end
            seg_bytes++;
          end
        end
      end
      if (din_next) begin
        pulses++;
        if (pulses > 1 && (cyc - last_pulse) != 8) bad_intervals++;
        last_pulse = cyc;
        din = data_byte(cfg_seed, data_idx);
        data_idx++;
      end
    end
  end

  task automatic applyStimulus(input vec_t v, output bit got);
    got      = 1'b0;
    cfg_seed = v.seed;
    cfg_wip  = v.wip_busy;
    @(posedge clk); #1;
    op      = v.op;
    address = v.addr;
    len_m1  = v.len_m1;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    op      = ~v.op;
    address = 24'h000000;
    len_m1  = 8'h00;
    checkOutput("busy_after_start", busy, 1);
    checkOutput("error_cleared_on_start", error, 0);
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (v.poke && (i == 20 || i == 300)) begin
        op      = 1'b1;
        address = 24'hFFFFFF;
        len_m1  = 8'h07;
        start   = 1'b1;
      end
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic checkTxn(input vec_t v, input bit got);
    logic [7:0] exp_q[$];
    checkOutput("done_seen", got, 1);
    checkOutput("error_with_done", error, v.exp_error);
    checkOutput("busy_low_at_done", busy, 0);
    checkOutput("cs_high_at_done", mspi_cs, 1);
    @(posedge clk); #1;
    checkOutput("done_one_cycle", done, 0);
    checkOutput("error_held", error, v.exp_error);
    exp_q = {8'hFF, 8'hFF, 8'h06, v.exp_opcode,
             v.addr[23:16], v.addr[15:8], v.addr[7:0]};
    for (int k = 0; k < v.exp_pulses; k++) exp_q.push_back(data_byte(v.seed, k));
    exp_q.push_back(8'h05);
    checkOutput("stream_len", rx_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++)
      checkOutput($sformatf("stream_byte%0d", k), rx_q[k], exp_q[k]);
    checkOutput("status_bytes", status_cnt, v.exp_status);
    checkOutput("din_next_count", pulses, v.exp_pulses);
    checkOutput("din_next_spacing", bad_intervals, 0);
    checkOutput("gap_count", gap_runs, 3);
    checkOutput("gap_width", gap_bad, 0);
    checkOutput("wren_latency", wren_cyc - start_cyc, 17 + GAP);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit got;
    checks   = 0;
    failures = 0;
    cfg_seed = 0;
    cfg_wip  = 0;
    resetn   = 1'b0;
    start    = 1'b0;
    op       = 1'b0;
    address  = 24'h0;
    len_m1   = 8'h0;

    //            op    addr        len    seed wip  poke  opc    stat err pulses
    vecs[0] = '{1'b0, 24'h012345, 8'd0,   0,   3,   0, 8'h20, 4, 1'b0, 0};
    vecs[1] = '{1'b1, 24'h000100, 8'd2,   0,   1,   1, 8'h02, 2, 1'b0, 3};
    vecs[2] = '{1'b1, 24'h0012F0, 8'd255, 1,   0,   0, 8'h02, 1, 1'b0, 256};
    vecs[3] = '{1'b0, 24'hFFF000, 8'd0,   0,   1000, 0, 8'h20, 4, 1'b1, 0};
    vecs[4] = '{1'b0, 24'h00A5A5, 8'd0,   0,   0,   0, 8'h20, 1, 1'b0, 0};
    vecs[5] = '{1'b1, 24'hFFFFFF, 8'd0,   2,   2,   0, 8'h02, 3, 1'b0, 1};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_cs", mspi_cs, 1);
    checkOutput("reset_di", mspi_di_w, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_din_next", din_next, 0);
    checkOutput("reset_error", error, 0);
    checkOutput("hold_driven", mspi_hold_w, 1);
    checkOutput("wp_driven", mspi_wp_w, 1);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(posedge clk);

    for (int n = 0; n < 6; n++) begin
      $display("[TB] vector %0d op=%0d addr=0x%06h", n, vecs[n].op, vecs[n].addr);
      applyStimulus(vecs[n], got);
      checkTxn(vecs[n], got);
      repeat (3) @(posedge clk);
    end

    // Reset asserted while program data is streaming must deselect at once.
    $display("[TB] reset during DATA");
    cfg_seed = 1;
    cfg_wip  = 0;
    @(posedge clk); #1;
    op      = 1'b1;
    address = 24'h000200;
    len_m1  = 8'd255;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (pulses >= 4) break;
      @(posedge clk); #1;
    end
    checkOutput("reached_data", (pulses >= 4), 1);
    @(posedge clk); #3;
    resetn = 1'b0;
    #1;
    checkOutput("midreset_cs", mspi_cs, 1);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_din_next", din_next, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    applyStimulus(vecs[0], got);
    checkTxn(vecs[0], got);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flash_writer.md
FLASH_WRITER -- requirements
Module: flash_writer

Interface
REQ-001 Parameter GAP_CYCLES, 2, number of clk cycles mspi_cs is held high between flash commands.
REQ-002 Parameter POLL_LIMIT, 22'h3FFFFF, maximum number of status bytes read before timeout.
REQ-003 clk  in  1  system clock; the flash SCK is driven from clk outside this block; one bit is transferred per clk cycle.
REQ-004 resetn  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle request; sampled only in IDLE.
REQ-006 op  in  1  0 = 4 KB sector erase (0x20), 1 = page program (0x02); captured on start.
REQ-007 address  in  24  flash byte address; captured on start.
REQ-008 len_m1  in  8  page-program byte count minus 1 (1..256 bytes); captured on start; ignored for erase.
REQ-009 din  in  8  current program byte; must be stable whenever din_next is not pulsing.
REQ-010 din_next  out  1  one-cycle pulse: din was latched; caller presents the next byte within 7 cycles.
REQ-011 busy  out  1  high from the cycle after an accepted start until done.
REQ-012 done  out  1  one-cycle pulse when the operation ends.
REQ-013 error  out  1  set with done on poll timeout; cleared on the next accepted start.
REQ-014 mspi_cs  out  1  flash chip select, active-low.
REQ-015 mspi_di  inout  1  IO0; always driven (serial data to the flash).
REQ-016 mspi_do  inout  1  IO1; never driven; serial data from the flash.
REQ-017 mspi_hold, mspi_wp  inout  1  each constantly driven 1.

Function
REQ-018 All serial fields SHALL be sent MSB first on mspi_di, changing on the clk rising edge; mspi_do SHALL be sampled on the clk rising edge.
REQ-019 FSM states SHALL be IDLE, EXIT, GAP, WREN, CMD, DATA, POLL_CMD, POLL_RD, DONE.
REQ-020 IDLE: start=1 SHALL capture the inputs, set busy, drive mspi_cs low and enter EXIT on the same edge.
REQ-021 EXIT: 16 cycles of mspi_di=1 SHALL be sent to leave continuous dual-read mode, followed by GAP.
REQ-022 GAP: mspi_cs SHALL be high for exactly GAP_CYCLES cycles, then proceed to WREN, CMD or POLL_CMD in sequence.
REQ-023 WREN: 8 bits of 0x06 SHALL be sent, followed by GAP.
REQ-024 CMD: 32 bits SHALL be sent (opcode, then address[23:0]); for erase the next state is GAP then POLL_CMD, and for program it is DATA.
REQ-025 DATA: din SHALL be latched and din_next pulsed on the last address-bit cycle and on bit 0 of every byte except the final one; len_m1+1 bytes SHALL be sent, followed by GAP.
REQ-026 POLL_CMD: 8 bits of 0x05 SHALL be sent, followed by POLL_RD with mspi_cs still low.
REQ-027 POLL_RD: status bytes SHALL be shifted continuously; when a completed byte has bit0 (WIP)=0, mspi_cs SHALL go high and the FSM SHALL enter DONE.
REQ-028 POLL_RD: when the POLL_LIMIT-th byte still shows WIP=1, error SHALL be set, mspi_cs SHALL go high and the FSM SHALL enter DONE.
REQ-029 DONE: done SHALL pulse, busy SHALL drop on the same edge, and the FSM SHALL return to IDLE.
REQ-030 start while busy SHALL be ignored.
REQ-031 No page-boundary check SHALL be made; a program crossing a 256-byte page wraps inside the flash.
REQ-032 Latency from start to the first WREN bit SHALL be 17+GAP_CYCLES cycles.

Reset
REQ-033 On resetn low: state=IDLE, mspi_cs=1, mspi_di=1, busy=0, done=0, din_next=0, error=0, all counters 0.
REQ-034 Reset mid-operation SHALL deselect the flash immediately (asynchronously); no recovery command is issued.

Structure
REQ-035 Package flash_pkg SHALL hold the opcodes CMD_WREN, CMD_PP, CMD_SE, CMD_RDSR1 and the FSM state enum.
REQ-036 One sub-module, spi_shift8, SHALL implement the 8-bit load/shift-out/shift-in register with a bit counter and a byte-complete strobe.

Verification
REQ-037 Erase at 0x012345 with a model returning WIP=1 for 3 bytes: bench sees 16 ones, 0x06, 0x20 0x01 0x23 0x45, 0x05, 4 status bytes, done=1, error=0.
REQ-038 Program of 3 bytes AA 55 C3 at 0x000100: wire shows 0x02 00 01 00 AA 55 C3; exactly 3 din_next pulses, each 8 cycles apart.
REQ-039 Program with len_m1=255: exactly 256 data bytes and 256 din_next pulses; cs high for GAP_CYCLES between commands.
REQ-040 POLL_LIMIT=4 with WIP stuck at 1: done and error after 4 status bytes; cs high.
REQ-041 resetn low during DATA: mspi_cs=1 and busy=0 immediately; a subsequent start runs a clean erase.
REQ-042 start pulsed while busy: no effect on wire traffic or captured address.
